// File: rtl/zero_rle_decoder.sv
// Zero-run-length decoder: expands literal / zero-run tokens into a dense
// one-element-per-cycle stream, with frame position tracking and run overflow flag.
module zero_rle_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int RUN_WIDTH  = 8,
    parameter int FRAME_LEN  = 64,
    parameter int CNT_WIDTH  = $clog2(FRAME_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_is_run,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         err_run_ovf
);
    typedef enum logic {S_FETCH, S_RUN} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);
    localparam logic [RUN_WIDTH-1:0] RUN_ONE  = RUN_WIDTH'(1);

    state_t               state;
    logic [RUN_WIDTH-1:0] run_left;
    logic [CNT_WIDTH-1:0] elem_cnt;
    logic                 slot_free;
    logic                 accept;
    logic                 at_last;
    logic [RUN_WIDTH-1:0] run_code;

    function automatic logic [CNT_WIDTH-1:0] next_cnt(input logic [CNT_WIDTH-1:0] c);
        return (c == LAST_IDX) ? '0 : c + 1'b1;
    endfunction

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !rst && (state == S_FETCH) && slot_free;
    assign accept    = in_valid && in_ready;
    assign run_code  = in_data[RUN_WIDTH-1:0];
    assign at_last   = (elem_cnt == LAST_IDX);

    // Output register stage: every load also advances the frame position
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            run_left    <= '0;
            elem_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            err_run_ovf <= 1'b0;
        end else if (state == S_FETCH) begin
            if (accept) begin
                out_valid <= 1'b1;
                out_last  <= at_last;
                elem_cnt  <= next_cnt(elem_cnt);
                if (!in_is_run) begin
                    out_data <= in_data;
                end else begin
                    out_data <= '0;
                    // A multi-zero run starting on the last slot cannot fit the frame
                    if (run_code != '0 && at_last) begin
                        err_run_ovf <= 1'b1;
                        run_left    <= '0;
                    end else begin
                        run_left <= run_code;
                        if (run_code != '0)
                            state <= S_RUN;
                    end
                end
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
        end else if (slot_free) begin
            out_valid <= 1'b1;
            out_data  <= '0;
            out_last  <= at_last;
            elem_cnt  <= next_cnt(elem_cnt);
            if (at_last && run_left > RUN_ONE) begin
                err_run_ovf <= 1'b1;
                run_left    <= '0;
                state       <= S_FETCH;
            end else begin
                run_left <= run_left - 1'b1;
                if (run_left == RUN_ONE)
                    state <= S_FETCH;
            end
        end
    end
endmodule

// File: tb/tb_zero_rle_decoder.sv
// Randomized and directed bench for zero_rle_decoder against a token-expansion model.
module tb_zero_rle_decoder;
    localparam int DW = 8;
    localparam int RW = 8;
    localparam int FL = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_is_run = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          err_run_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW:0] got[$];
    logic [DW:0] expq[$];
    int          mpos;
    logic        merr;
    bit          rnd_ready = 1'b0;

    zero_rle_decoder #(.DATA_WIDTH(DW), .RUN_WIDTH(RW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_is_run(in_is_run),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .err_run_ovf(err_run_ovf)
    );

    always #5 clk = ~clk;

    // Record every element that completes a handshake at the coming edge
    always @(negedge clk)
        if (!rst && out_valid && out_ready) got.push_back({out_last, out_data});

    always @(posedge clk)
        if (rnd_ready) begin
            #1;
            out_ready = ($urandom_range(0, 9) < 7);
        end

    // Reference: a frame holds FL slots; a run that does not fit is truncated and flagged
    task automatic model_tok(input bit r, input logic [DW-1:0] d);
        logic [RW-1:0] code;
        int n, room;
        if (!r) begin
            expq.push_back({(mpos == FL - 1), d});
            mpos = (mpos + 1) % FL;
        end else begin
            code = d[RW-1:0];
            n    = int'(code) + 1;
            room = FL - mpos;
            if (n > room) begin
                merr = 1'b1;
                n    = room;
            end
            for (int k = 0; k < n; k++) begin
                expq.push_back({(mpos == FL - 1), {DW{1'b0}}});
                mpos = (mpos + 1) % FL;
            end
        end
    endtask

    task automatic do_reset();
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete(); expq.delete();
        mpos = 0; merr = 1'b0;
    endtask

    task automatic send(input bit r, input logic [DW-1:0] d, output int waits, output bit tmo);
        bit acc;
        in_valid = 1'b1; in_is_run = r; in_data = d;
        waits = 0; tmo = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                tmo = 1'b0;
                break;
            end
            waits++;
        end
        in_valid = 1'b0;
        if (!tmo) model_tok(r, d);
    endtask

    task automatic drain(output bit tmo);
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        tmo = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!out_valid) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_is_run = 1'b0; in_data = 8'h5A;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b want 0", out_last); end
        n_cmp++; if (err_run_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_run_ovf); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_literals();
        logic [DW-1:0] lits[4];
        int w; bit t;
        lits = '{8'h05, 8'h80, 8'h7F, 8'hFF};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, lits[i], w, t);
            n_cmp++; if (w !== 0 || t) begin n_bad++; $display("FAIL lit_stall[%0d]: got %0d waits want 0", i, w); end
            n_cmp++; if (out_valid !== 1'b1 || out_data !== lits[i]) begin
                n_bad++; $display("FAIL lit_latency[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, lits[i]);
            end
        end
        drain(t);
        n_cmp++; if (got.size() !== 4) begin n_bad++; $display("FAIL lit_count: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_cmp++; if (got[i] !== expq[i]) begin n_bad++; $display("FAIL lit_elem[%0d]: got %h want %h", i, got[i], expq[i]); end
        end
    endtask

    task automatic test_run();
        int w; bit t;
        do_reset();
        send(1'b1, 8'd3, w, t);
        send(1'b0, 8'h11, w, t);
        n_cmp++; if (w !== 3) begin n_bad++; $display("FAIL run_in_ready_low: got %0d cycles want 3", w); end
        drain(t);
        n_cmp++; if (got.size() !== 5 || t) begin n_bad++; $display("FAIL run_count: got %0d want 5", got.size()); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_cmp++; if (got[i] !== expq[i]) begin n_bad++; $display("FAIL run_elem[%0d]: got %h want %h", i, got[i], expq[i]); end
        end
    endtask

    task automatic test_zero_run();
        int w, wsum; bit t;
        do_reset();
        wsum = 0;
        send(1'b0, 8'h01, w, t); wsum += w;
        send(1'b1, 8'h00, w, t); wsum += w;
        send(1'b0, 8'h02, w, t); wsum += w;
        n_cmp++; if (wsum !== 0) begin n_bad++; $display("FAIL zrun_stall: got %0d waits want 0", wsum); end
        drain(t);
        n_cmp++; if (got.size() !== 3) begin n_bad++; $display("FAIL zrun_count: got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_cmp++; if (got[i] !== expq[i]) begin n_bad++; $display("FAIL zrun_elem[%0d]: got %h want %h", i, got[i], expq[i]); end
        end
    endtask

    task automatic test_back_to_back_stall();
        bit pat[5];
        int w; bit t;
        logic [DW:0] held;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        send(1'b0, 8'hA5, w, t);
        out_ready = 1'b0;
        held = {out_last, out_data};
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b1 || {out_last, out_data} !== held) begin
            n_bad++; $display("FAIL stall_hold_lit: got v=%b %h want v=1 %h", out_valid, {out_last, out_data}, held);
        end
        out_ready = 1'b1;
        send(1'b1, 8'd2, w, t);
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i];
            @(negedge clk);
            if (!pat[i]) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin
                    n_bad++; $display("FAIL stall_hold_run[%0d]: got v=%b d=%h want v=1 d=00", i, out_valid, out_data);
                end
            end
            @(posedge clk);
            #1;
        end
        drain(t);
        n_cmp++; if (got.size() !== 4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_cmp++; if (got[i] !== expq[i]) begin n_bad++; $display("FAIL stall_elem[%0d]: got %h want %h", i, got[i], expq[i]); end
        end
    endtask

    task automatic test_frame_overflow();
        int w; bit t;
        do_reset();
        for (int i = 0; i < 62; i++) send(1'b0, 8'($urandom_range(1, 255)), w, t);
        send(1'b1, 8'd4, w, t);
        send(1'b0, 8'h09, w, t);
        drain(t);
        n_cmp++; if (got.size() !== 65) begin n_bad++; $display("FAIL frame_count: got %0d want 65", got.size()); end
        if (got.size() == 65) begin
            n_cmp++; if (got[63] !== 9'h100) begin n_bad++; $display("FAIL frame_last63: got %h want 100", got[63]); end
            n_cmp++; if (got[64] !== 9'h009) begin n_bad++; $display("FAIL frame_next0: got %h want 009", got[64]); end
        end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_cmp++; if (got[i] !== expq[i]) begin n_bad++; $display("FAIL frame_elem[%0d]: got %h want %h", i, got[i], expq[i]); end
        end
        n_cmp++; if (err_run_ovf !== 1'b1) begin n_bad++; $display("FAIL frame_err: got %b want 1", err_run_ovf); end
    endtask

    task automatic test_reset_mid_run();
        int w; bit t;
        do_reset();
        for (int i = 0; i < 63; i++) send(1'b0, 8'h44, w, t);
        send(1'b1, 8'd5, w, t);
        send(1'b1, 8'd200, w, t);
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (err_run_ovf !== 1'b1) begin n_bad++; $display("FAIL mid_err_pre: got %b want 1", err_run_ovf); end
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_ready_rst: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        n_cmp++; if (err_run_ovf !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", err_run_ovf); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        got.delete(); expq.delete(); mpos = 0; merr = 1'b0;
        send(1'b0, 8'h33, w, t);
        drain(t);
        n_cmp++; if (got.size() !== 1 || got[0] !== 9'h033) begin
            n_bad++; $display("FAIL mid_next: got n=%0d first=%h want n=1 033", got.size(), (got.size() > 0) ? got[0] : 9'h1FF);
        end
    endtask

    task automatic test_random();
        int w, shown; bit t, r;
        logic [DW-1:0] d;
        do_reset();
        rnd_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            r = ($urandom_range(0, 9) < 3);
            if (r && $urandom_range(0, 7) != 0) d = 8'($urandom_range(0, 5));
            else d = 8'($urandom);
            send(r, d, w, t);
            if (t) begin
                n_cmp++; n_bad++; $display("FAIL rnd_accept_timeout: token %0d never accepted", i);
                break;
            end
        end
        drain(t);
        n_cmp++; if (t) begin n_bad++; $display("FAIL rnd_drain_timeout: out_valid stuck at %b", out_valid); end
        n_cmp++; if (got.size() !== expq.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", got.size(), expq.size()); end
        shown = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            n_cmp++;
            if (got[i] !== expq[i]) begin
                n_bad++;
                if (shown < 10) $display("FAIL rnd_elem[%0d]: got %h want %h", i, got[i], expq[i]);
                shown++;
            end
        end
        n_cmp++; if (err_run_ovf !== merr) begin n_bad++; $display("FAIL rnd_err: got %b want %b", err_run_ovf, merr); end
    endtask

    initial begin
        test_reset();
        test_literals();
        test_run();
        test_zero_run();
        test_back_to_back_stall();
        test_frame_overflow();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
